// File: rtl/ethpipe_gmii_tx.sv
// GMII transmit engine: streams one TX slot from dual-port RAM as preamble/SFD, payload,
// optional zero pad and FCS, then holds the inter-frame gap and reports completion.
module ethpipe_gmii_tx #(
    parameter int unsigned RAM_LATENCY   = 2,
    parameter int unsigned MIN_FRAME_LEN = 60,
    parameter int unsigned MAX_FRAME_LEN = 1514,
    parameter int unsigned IFG_CYCLES    = 12,
    parameter bit          ADD_PAD       = 1'b1
) (
    input  logic        clk_125,
    input  logic        rstn,
    input  logic        tx_start,
    input  logic [11:0] tx_frame_len,
    input  logic [31:0] global_counter,
    output logic [11:0] slot_tx_eth_address,
    input  logic [15:0] slot_tx_eth_q,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic        tx_busy,
    output logic        tx_complete,
    output logic        tx_error,
    output logic [31:0] tx_timestamp
);

    // Preamble+SFD is 8 wire cycles, minus one for the output register. Prefetch length and
    // RAM latency cancel, so the fetch pointer trails acceptance by a fixed 7 cycles.
    localparam logic [11:0] FETCH_LEAD = 12'd7;

    typedef enum logic [3:0] {
        StIdle, StPrefetch, StPreamble, StSfd, StData, StPad, StFcs, StIfg, StReject
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [11:0] byte_q, byte_d;
    logic [11:0] len_q, len_d;
    logic [11:0] fc_q, fc_d;
    logic [31:0] crc_q, crc_d;
    logic [31:0] ts_q, ts_d;
    logic [11:0] addr_q, addr_d;
    logic [7:0]  txd_q, txd_d;
    logic        en_q, en_d;
    logic        busy_q, busy_d;
    logic        cmp_q, cmp_d;
    logic        err_q, err_d;
    logic [31:0] fcs;
    logic [11:0] fetch, word, last;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        len_d   = len_q;
        crc_d   = crc_q;
        ts_d    = ts_q;
        txd_d   = 8'h00;
        en_d    = 1'b0;
        fcs     = 32'h0;

        case (state_q)
            StIdle: begin
                if (tx_start) begin
                    if (tx_frame_len != 12'd0 && tx_frame_len <= 12'(MAX_FRAME_LEN)) begin
                        len_d   = tx_frame_len;
                        cnt_d   = 8'd0;
                        state_d = (RAM_LATENCY > 1) ? StPrefetch : StPreamble;
                    end else begin
                        state_d = StReject;
                    end
                end
            end
            StPrefetch: begin
                if (cnt_q == 8'(RAM_LATENCY - 2)) begin
                    state_d = StPreamble;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StPreamble: begin
                if (cnt_q == 8'd6) state_d = StSfd;
                else               cnt_d   = cnt_q + 8'd1;
            end
            StSfd: begin
                state_d = StData;
                byte_d  = 12'd0;
                ts_d    = global_counter;
            end
            StData: begin
                if (byte_q == len_q - 12'd1) begin
                    if (ADD_PAD && len_q < 12'(MIN_FRAME_LEN)) begin
                        state_d = StPad;
                        byte_d  = byte_q + 12'd1;
                    end else begin
                        state_d = StFcs;
                        cnt_d   = 8'd0;
                    end
                end else begin
                    byte_d = byte_q + 12'd1;
                end
            end
            StPad: begin
                if (byte_q == 12'(MIN_FRAME_LEN - 1)) begin
                    state_d = StFcs;
                    cnt_d   = 8'd0;
                end else begin
                    byte_d = byte_q + 12'd1;
                end
            end
            StFcs: begin
                if (cnt_q == 8'd3) begin
                    state_d = StIfg;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StIfg: begin
                if (cnt_q == 8'(IFG_CYCLES - 1)) state_d = StIdle;
                else                             cnt_d   = cnt_q + 8'd1;
            end
            StReject: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        // Output registers carry the byte for the state being entered.
        case (state_d)
            StPreamble: begin
                txd_d = 8'h55;
                en_d  = 1'b1;
            end
            StSfd: begin
                txd_d = 8'hD5;
                en_d  = 1'b1;
                crc_d = 32'hFFFFFFFF;
            end
            StData: begin
                txd_d = byte_d[0] ? slot_tx_eth_q[7:0] : slot_tx_eth_q[15:8];
                en_d  = 1'b1;
                crc_d = crc32_byte(crc_q, txd_d);
            end
            StPad: begin
                en_d  = 1'b1;
                crc_d = crc32_byte(crc_q, 8'h00);
            end
            StFcs: begin
                fcs   = ~crc_q >> {cnt_d[1:0], 3'b000};
                txd_d = fcs[7:0];
                en_d  = 1'b1;
            end
            default: ;
        endcase

        busy_d = !(state_d inside {StIdle, StReject});
        cmp_d  = (state_d == StReject) || (state_q == StIfg && state_d == StIdle);
        err_d  = (state_d == StReject);

        fc_d   = busy_d ? fc_q + 12'd1 : 12'd0;
        fetch  = fc_d - FETCH_LEAD;
        word   = fetch >> 1;
        last   = (len_q - 12'd1) >> 1;
        addr_d = (fc_d >= FETCH_LEAD) ? ((word > last) ? last : word) : 12'd0;
    end

    always_ff @(posedge clk_125 or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            byte_q  <= 12'd0;
            len_q   <= 12'd0;
            fc_q    <= 12'd0;
            crc_q   <= 32'hFFFFFFFF;
            ts_q    <= 32'd0;
            addr_q  <= 12'd0;
            txd_q   <= 8'h00;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            cmp_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            len_q   <= len_d;
            fc_q    <= fc_d;
            crc_q   <= crc_d;
            ts_q    <= ts_d;
            addr_q  <= addr_d;
            txd_q   <= txd_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            cmp_q   <= cmp_d;
            err_q   <= err_d;
        end
    end

    assign slot_tx_eth_address = addr_q;
    assign gmii_txd            = txd_q;
    assign gmii_tx_en          = en_q;
    assign gmii_tx_er          = 1'b0;
    assign tx_busy             = busy_q;
    assign tx_complete         = cmp_q;
    assign tx_error            = err_q;
    assign tx_timestamp        = ts_q;

endmodule

// File: tb/tb_ethpipe_gmii_tx.sv
// Directed bench: a padding and a non-padding instance share stimulus, each with its own
// two-cycle RAM model; wire bytes are compared against a reference frame built here.
`timescale 1ns / 1ps
module tb_ethpipe_gmii_tx;

    logic        clk = 1'b0;
    logic        rstn;
    logic        tx_start;
    logic [11:0] tx_frame_len;
    logic [31:0] gc_base;
    logic [31:0] global_counter;
    int          cyc = 0;

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign global_counter = gc_base + 32'(cyc);

    logic [15:0] mem [4096];
    logic [11:0] addr [2];
    logic [15:0] p0 [2];
    logic [15:0] p1 [2];
    logic [7:0]  txd [2];
    logic        en [2];
    logic        er [2];
    logic        busy [2];
    logic        cmp [2];
    logic        err [2];
    logic [31:0] ts [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            p0[d] <= mem[addr[d]];
            p1[d] <= p0[d];
        end
    end

    ethpipe_gmii_tx #(.ADD_PAD(1'b1)) u_dut_pad (
        .clk_125(clk), .rstn(rstn), .tx_start(tx_start), .tx_frame_len(tx_frame_len),
        .global_counter(global_counter), .slot_tx_eth_address(addr[0]),
        .slot_tx_eth_q(p1[0]), .gmii_txd(txd[0]), .gmii_tx_en(en[0]), .gmii_tx_er(er[0]),
        .tx_busy(busy[0]), .tx_complete(cmp[0]), .tx_error(err[0]), .tx_timestamp(ts[0])
    );

    ethpipe_gmii_tx #(.ADD_PAD(1'b0)) u_dut_nopad (
        .clk_125(clk), .rstn(rstn), .tx_start(tx_start), .tx_frame_len(tx_frame_len),
        .global_counter(global_counter), .slot_tx_eth_address(addr[1]),
        .slot_tx_eth_q(p1[1]), .gmii_txd(txd[1]), .gmii_tx_en(en[1]), .gmii_tx_er(er[1]),
        .tx_busy(busy[1]), .tx_complete(cmp[1]), .tx_error(err[1]), .tx_timestamp(ts[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] cap0 [$];
    logic [7:0] cap1 [$];
    int rises [2];
    int cur_run [2];
    int run_len [2];
    int rise_cyc [2];
    int fall_cyc [2];
    int cmp_cnt [2];
    int cmp_cyc [2];
    int max_addr [2];
    bit err_at_cmp [2];
    bit busy_at_cmp [2];
    bit prev_en [2];
    int rises0 [2];
    int cmp0 [2];
    int start_cyc;

    function automatic logic [7:0] mem_byte(input int k);
        logic [15:0] w;
        w = mem[k >> 1];
        return k[0] ? w[7:0] : w[15:8];
    endfunction

    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ b[i];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    function automatic int frame_errs(input int d, input int len, input bit pad);
        logic [7:0]  e [$];
        logic [7:0]  g [$];
        logic [31:0] crc;
        logic [7:0]  b;
        int          n;
        int          bad;
        for (int i = 0; i < 7; i++) e.push_back(8'h55);
        e.push_back(8'hD5);
        n   = (pad && len < 60) ? 60 : len;
        crc = 32'hFFFFFFFF;
        for (int k = 0; k < n; k++) begin
            b = (k < len) ? mem_byte(k) : 8'h00;
            e.push_back(b);
            crc = crc_step(crc, b);
        end
        crc = ~crc;
        for (int i = 0; i < 4; i++) e.push_back(crc[8*i +: 8]);
        if (d == 0) g = cap0;
        else        g = cap1;
        bad = (g.size() != e.size()) ? 1000 : 0;
        for (int i = 0; i < e.size() && i < g.size(); i++) begin
            if (g[i] !== e[i]) bad++;
        end
        return bad;
    endfunction

    task automatic sample();
        for (int d = 0; d < 2; d++) begin
            if (en[d]) begin
                if (d == 0) cap0.push_back(txd[d]);
                else        cap1.push_back(txd[d]);
                if (!prev_en[d]) begin
                    rises[d]++;
                    rise_cyc[d] = cyc;
                    cur_run[d]  = 0;
                    max_addr[d] = 0;
                end
                cur_run[d]++;
            end else if (prev_en[d]) begin
                fall_cyc[d] = cyc;
                run_len[d]  = cur_run[d];
            end
            if (int'(addr[d]) > max_addr[d]) max_addr[d] = int'(addr[d]);
            if (cmp[d]) begin
                cmp_cnt[d]++;
                cmp_cyc[d]     = cyc;
                err_at_cmp[d]  = err[d];
                busy_at_cmp[d] = busy[d];
            end
            prev_en[d] = en[d];
        end
    endtask

    // restart_at / rst_at: loop iteration for a second tx_start or a reset pulse (-1 = none).
    task automatic run_frame(input string tag, input int len, input int restart_at,
                             input int rst_at, input int min_cyc, input int budget);
        bit done;
        cap0.delete();
        cap1.delete();
        for (int d = 0; d < 2; d++) begin
            rises0[d] = rises[d];
            cmp0[d]   = cmp_cnt[d];
        end
        @(negedge clk);
        tx_start     = 1'b1;
        tx_frame_len = 12'(len);
        start_cyc    = cyc;
        gc_base      = 32'h1000 - 32'(cyc);
        done         = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            sample();
            tx_start = (i == restart_at);
            if (i == restart_at) tx_frame_len = 12'd5;
            if (i == rst_at) begin
                rstn = 1'b0;
                #1;
                for (int d = 0; d < 2; d++) begin
                    check_eq($sformatf("%s_rst_en%0d", tag, d), 32'(en[d]), 32'd0);
                    check_eq($sformatf("%s_rst_busy%0d", tag, d), 32'(busy[d]), 32'd0);
                end
                @(negedge clk);
                rstn = 1'b1;
                return;
            end
            done = (cmp_cnt[0] != cmp0[0]) && (cmp_cnt[1] != cmp0[1]);
            if (done && i >= min_cyc) break;
        end
        check_eq({tag, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rstn         = 1'b0;
        tx_start     = 1'b0;
        tx_frame_len = 12'd0;
        gc_base      = 32'd0;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("rst_txd%0d", d), 32'(txd[d]), 32'd0);
            check_eq($sformatf("rst_en%0d", d), 32'(en[d]), 32'd0);
            check_eq($sformatf("rst_busy%0d", d), 32'(busy[d]), 32'd0);
            check_eq($sformatf("rst_cmp%0d", d), 32'({cmp[d], err[d], er[d]}), 32'd0);
            check_eq($sformatf("rst_ts%0d", d), ts[d], 32'd0);
            check_eq($sformatf("rst_addr%0d", d), 32'(addr[d]), 32'd0);
        end
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // "123456789"; the unused low byte of the last word must never reach the wire.
        mem[0] = 16'h3132; mem[1] = 16'h3334; mem[2] = 16'h3536;
        mem[3] = 16'h3738; mem[4] = 16'h39AA;
        run_frame("t1", 9, -1, -1, 2, 300);
        check_eq("t1_np_run", 32'(run_len[1]), 32'd21);
        check_eq("t1_np_rise", 32'(rise_cyc[1]), 32'(start_cyc + 2));
        check_eq("t1_np_first", 32'(cap1[8]), 32'h31);
        check_eq("t1_np_fcs", {cap1[17], cap1[18], cap1[19], cap1[20]}, 32'h2639F4CB);
        check_eq("t1_np_bytes", 32'(frame_errs(1, 9, 1'b0)), 32'd0);
        check_eq("t1_np_ifg", 32'(cmp_cyc[1] - fall_cyc[1]), 32'd12);
        check_eq("t1_np_err", 32'(err_at_cmp[1]), 32'd0);
        check_eq("t1_np_busy_at_cmp", 32'(busy_at_cmp[1]), 32'd0);
        check_eq("t1_np_ts", ts[1], 32'h1009);
        check_eq("t1_pad_ts", ts[0], 32'h1009);
        check_eq("t1_pad_run", 32'(run_len[0]), 32'd72);
        check_eq("t1_pad_bytes", 32'(frame_errs(0, 9, 1'b1)), 32'd0);

        for (int i = 0; i < 7; i++) mem[i] = 16'(32'hA0F0 + i * 32'h1357);
        run_frame("t2", 14, -1, -1, 2, 300);
        check_eq("t2_pad_run", 32'(run_len[0]), 32'd72);
        check_eq("t2_pad_zero", 32'(cap0[30]), 32'h00);
        check_eq("t2_pad_bytes", 32'(frame_errs(0, 14, 1'b1)), 32'd0);
        check_eq("t2_np_run", 32'(run_len[1]), 32'd26);
        check_eq("t2_np_bytes", 32'(frame_errs(1, 14, 1'b0)), 32'd0);

        for (int i = 0; i < 757; i++) mem[i] = 16'($urandom);
        run_frame("t3", 1514, -1, -1, 2, 2000);
        check_eq("t3_run", 32'(run_len[0]), 32'd1526);
        check_eq("t3_one_run", 32'(rises[0] - rises0[0]), 32'd1);
        check_eq("t3_bytes", 32'(frame_errs(0, 1514, 1'b1)), 32'd0);
        check_eq("t3_max_addr", 32'(max_addr[0]), 32'd756);
        check_eq("t3_np_bytes", 32'(frame_errs(1, 1514, 1'b0)), 32'd0);

        run_frame("t4a", 0, -1, -1, 5, 50);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("t4a_cmp_cyc%0d", d), 32'(cmp_cyc[d]), 32'(start_cyc + 1));
            check_eq($sformatf("t4a_err%0d", d), 32'(err_at_cmp[d]), 32'd1);
            check_eq($sformatf("t4a_no_en%0d", d), 32'(rises[d] - rises0[d]), 32'd0);
        end
        run_frame("t4b", 1515, -1, -1, 5, 50);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("t4b_cmp_cyc%0d", d), 32'(cmp_cyc[d]), 32'(start_cyc + 1));
            check_eq($sformatf("t4b_err%0d", d), 32'(err_at_cmp[d]), 32'd1);
            check_eq($sformatf("t4b_no_en%0d", d), 32'(rises[d] - rises0[d]), 32'd0);
            check_eq($sformatf("t4b_one_cmp%0d", d), 32'(cmp_cnt[d] - cmp0[d]), 32'd1);
        end

        run_frame("t5", 100, 30, -1, 2, 400);
        check_eq("t5_one_frame", 32'(rises[0] - rises0[0]), 32'd1);
        check_eq("t5_run", 32'(run_len[0]), 32'd112);
        check_eq("t5_bytes", 32'(frame_errs(0, 100, 1'b1)), 32'd0);
        check_eq("t5_one_cmp", 32'(cmp_cnt[0] - cmp0[0]), 32'd1);

        run_frame("t6", 200, -1, 50, 2, 400);
        repeat (2) @(negedge clk);

        run_frame("t7", 20, -1, -1, 2, 300);
        check_eq("t7_pad_run", 32'(run_len[0]), 32'd72);
        check_eq("t7_pad_bytes", 32'(frame_errs(0, 20, 1'b1)), 32'd0);
        check_eq("t7_np_run", 32'(run_len[1]), 32'd32);
        check_eq("t7_np_bytes", 32'(frame_errs(1, 20, 1'b0)), 32'd0);
        check_eq("t7_ts", ts[0], 32'h1009);
        check_eq("tx_er_low", 32'({er[0], er[1]}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ethpipe_gmii_tx.md
Name: ethpipe_gmii_tx

Overview:
Transmit engine for one ethpipe port: the mirror of the RX slot path. The host fills a TX frame slot in dual-port RAM over PCIe, then issues a start. This block reads the slot through the RAM's ethernet-side port and emits preamble/SFD, payload, zero pad and FCS on GMII, followed by the inter-frame gap. It reports completion and the SFD timestamp back to the PCIe register map, with the completion pulse crossing domains through clk_sync2.

Parameters:
RAM_LATENCY, 2, cycles from slot_tx_eth_address change to valid slot_tx_eth_q
MIN_FRAME_LEN, 60, minimum payload bytes before FCS; shorter frames are zero-padded
MAX_FRAME_LEN, 1514, largest accepted tx_frame_len
IFG_CYCLES, 12, idle cycles after the last FCS byte
ADD_PAD, 1, 1 = pad short frames to MIN_FRAME_LEN; 0 = send as-is

Ports:
clk_125  in  1  GMII transmit clock, 125 MHz (same clock drives RAM port B)
rstn  in  1  asynchronous active-low reset
tx_start  in  1  one-cycle start pulse, already synchronised to clk_125
tx_frame_len  in  12  payload length in bytes, excluding preamble/SFD/FCS; sampled with tx_start
global_counter  in  32  free-running timestamp counter
slot_tx_eth_address  out  12  word address into TX slot RAM
slot_tx_eth_q  in  16  RAM read data; first wire byte = [15:8], second = [7:0]
gmii_txd  out  8  GMII transmit data
gmii_tx_en  out  1  GMII transmit enable
gmii_tx_er  out  1  tied 0
tx_busy  out  1  high from accepted tx_start until end of IFG
tx_complete  out  1  one-cycle pulse at end of frame or at rejection
tx_error  out  1  valid with tx_complete; 1 = length rejected, nothing sent
tx_timestamp  out  32  global_counter captured in the SFD cycle; holds until next SFD

Behaviour:
- Reset (async, rstn=0) values: gmii_txd=0, gmii_tx_en=0, gmii_tx_er=0, tx_busy=0, tx_complete=0, tx_error=0, tx_timestamp=0, slot_tx_eth_address=0. State returns to IDLE. Asserting reset mid-frame drops gmii_tx_en immediately, with no FCS or IFG.
- States and transitions:
  - IDLE -> PREFETCH on tx_start when 1 <= tx_frame_len <= MAX_FRAME_LEN.
  - IDLE -> REJECT on tx_start when tx_frame_len = 0 or > MAX_FRAME_LEN.
  - REJECT lasts one cycle, then IDLE, with tx_complete=1 and tx_error=1. No GMII activity.
  - PREFETCH lasts RAM_LATENCY cycles with address 0. gmii_tx_en rises exactly RAM_LATENCY cycles after the tx_start cycle.
  - PREAMBLE: 7 cycles of 0x55.
  - SFD: 1 cycle of 0xD5; tx_timestamp <= global_counter in this cycle.
  - DATA: one byte per cycle. Byte k is taken from word k>>1, high byte for even k, low byte for odd k. The address must be pipelined ahead by RAM_LATENCY so there are no bubbles. For odd lengths the last word's [7:0] is ignored.
  - PAD: only if ADD_PAD=1 and len < MIN_FRAME_LEN; 0x00 bytes until MIN_FRAME_LEN bytes have been sent.
  - FCS: 4 bytes of IEEE 802.3 CRC32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF, final complement) over payload+pad, least-significant byte first.
  - IFG: gmii_tx_en=0, gmii_txd=0 for IFG_CYCLES cycles.
  - IFG -> IDLE with a tx_complete pulse (tx_error=0) in the first IDLE cycle. tx_busy falls in that same cycle.
- gmii_tx_en high time = 8 + max(len, ADD_PAD ? MIN_FRAME_LEN : len) + 4 contiguous cycles.
- tx_start while tx_busy=1 is ignored (no queueing). tx_frame_len is latched at acceptance; later changes have no effect.
- slot_tx_eth_address returns to 0 in IDLE. The block never writes the RAM.
- All outputs are registered; gmii_txd and gmii_tx_en change only on the clk_125 rising edge.

Test Plan:
- ADD_PAD=0, len=9, slot "123456789" -> 0x55 x7, 0xD5, 31..39, FCS 0x26 0x39 0xF4 0xCB; tx_en high 21 cycles; tx_complete 12 cycles after tx_en falls (+1), tx_error=0.
- ADD_PAD=1, len=14 -> 46 zero pad bytes; tx_en high 72 cycles; FCS matches the reference CRC model over 60 bytes.
- len=1514 random data -> 1526 contiguous tx_en cycles, no bubbles; bytes match slot order, high byte first; address reaches 756.
- len=0, then len=1515 -> no tx_en; tx_complete=1 and tx_error=1 exactly 1 cycle after each tx_start.
- tx_start pulsed again mid-DATA -> ignored; one frame only. Then rstn low mid-DATA -> tx_en=0 at once, tx_busy=0; a fresh start afterwards sends a clean frame.
- global_counter=0x1000 at the tx_start cycle (incrementing each cycle) -> tx_timestamp=0x1000+RAM_LATENCY+7.
